// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-requester arbiter and sequencer for the shared data memory `dm`.
// Port 0 is the CPU load/store path, port 1 a secondary master (DMA/loader).
// One request is latched into a transaction register and runs against `dm`
// for exactly one BUSY cycle. Read data returns with a one-cycle ack in ACK.
// The block then goes back to IDLE, where it arbitrates again.
//
// Parameters
//   RR        1 = round-robin on a tie, 0 = fixed priority (port 0 wins)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0/1                    request, held until that port's ack
//   we0/1                     1 = store, 0 = load
//   addr0/1 [6:0]             word address (dm addr[8:2])
//   wdata0/1 [31:0]           store data
//   ld0/1 [2:0], sv0/1 [1:0]  load / store width codes, passed to dm
//   ack0/1                    one-cycle completion pulse
//   rdata [31:0]              load result, valid with ack, held until next ACK
//   gnt [1:0]                 one-hot owner, 00 = none
//   busy                      high in BUSY and ACK
//   m_DMWr, m_addr, m_din,
//   m_LD, m_SV                dm port, all zero outside BUSY
//   m_dout [31:0]             dm read data (combinational from m_addr/m_LD)
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [6:0]  addr0,
    input  logic [6:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [2:0]  ld0,
    input  logic [2:0]  ld1,
    input  logic [1:0]  sv0,
    input  logic [1:0]  sv1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        m_DMWr,
    output logic [6:0]  m_addr,
    output logic [31:0] m_din,
    output logic [2:0]  m_LD,
    output logic [1:0]  m_SV,
    input  logic [31:0] m_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q,   gnt_d;
    logic        last_q,  last_d;    // 1 = port 1 was granted last
    logic        we_q,    we_d;
    logic [6:0]  addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ld_q,    ld_d;
    logic [1:0]  sv_q,    sv_d;
    logic [31:0] rdata_q, rdata_d;
    logic        win1;               // arbitration result: 1 = port 1 wins
    logic        in_busy;

    // NOTE: every signal written here gets its default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        sv_d    = sv_q;
        rdata_d = rdata_q;
        win1    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win1 = RR ? ~last_q : 1'b0;
                    end else begin
                        win1 = req1;
                    end
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    last_d  = win1;
                    we_d    = win1 ? we1    : we0;
                    addr_d  = win1 ? addr1  : addr0;
                    wdata_d = win1 ? wdata1 : wdata0;
                    ld_d    = win1 ? ld1    : ld0;
                    sv_d    = win1 ? sv1    : sv0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Captured for stores too; the requester simply ignores it.
                rdata_d = m_dout;
                state_d = S_ACK;
            end
            S_ACK: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;         // port 0 wins the first tie
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            sv_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            sv_q    <= sv_d;
            rdata_q <= rdata_d;
        end
    end

    // The dm port is gated by the registered state, so an asynchronous reset
    // during BUSY drops m_DMWr at once and no stale write can leak out.
    assign in_busy = (state_q == S_BUSY);
    assign m_DMWr  = in_busy & we_q;
    assign m_addr  = in_busy ? addr_q  : 7'd0;
    assign m_din   = in_busy ? wdata_q : 32'd0;
    assign m_LD    = in_busy ? ld_q    : 3'd0;
    assign m_SV    = in_busy ? sv_q    : 2'd0;

    assign busy  = (state_q != S_IDLE);
    assign gnt   = gnt_q;
    assign ack0  = (state_q == S_ACK) & gnt_q[0];
    assign ack1  = (state_q == S_ACK) & gnt_q[1];
    assign rdata = rdata_q;

endmodule
